// File: rtl/hash_msg_feeder_if.sv
// rtl/hash_msg_feeder_if.sv - source-side byte stream and hash-core handshake bundle
interface hash_msg_feeder_if #(
    parameter int CNT_W = 64
);
    logic             in_valid;
    logic [7:0]       in_data;
    logic             in_last;
    logic             in_ready;
    logic             m_valid;
    logic [7:0]       message;
    logic             m_ready;
    logic             fin_valid;
    logic [CNT_W-1:0] counter;
    logic             hash_ready;

    // master: the environment (byte source plus hash core); slave: the feeder
    modport master (
        output in_valid, in_data, in_last, m_ready, hash_ready,
        input  in_ready, m_valid, message, fin_valid, counter
    );

    modport slave (
        input  in_valid, in_data, in_last, m_ready, hash_ready,
        output in_ready, m_valid, message, fin_valid, counter
    );
endinterface

// File: rtl/hash_msg_feeder.sv
// rtl/hash_msg_feeder.sv - byte FIFO plus length tracker feeding the DES-S-box hash core
// Streams one message to the core, then holds its length until the digest is reported.
module hash_msg_feeder #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    hash_msg_feeder_if.slave bus
);
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]   OCC_FULL = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   OCC_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_STREAM = 2'd1,
        S_FINAL  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [8:0]       mem_d [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      occ_q, occ_d;
    logic [CNT_W-1:0] counter_q, counter_d;

    logic       in_ready;
    logic       push;
    logic       pop;
    logic       m_valid;
    logic [8:0] head;

    always_comb begin
        in_ready  = (occ_q != OCC_FULL);
        push      = bus.in_valid && in_ready;
        head      = mem_q[rd_ptr_q];
        m_valid   = (state_q == S_STREAM) && (occ_q != '0);
        pop       = m_valid && bus.m_ready;

        mem_d     = mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        occ_d     = occ_q;
        counter_d = counter_q;
        state_d   = state_q;

        if (push) begin
            mem_d[wr_ptr_q] = {bus.in_last, bus.in_data};
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push && !pop) begin
            occ_d = occ_q + OCC_ONE;
        end else if (pop && !push) begin
            occ_d = occ_q - OCC_ONE;
        end

        unique case (state_q)
            S_IDLE: begin
                // Leaving on the incoming push keeps first-byte latency at one cycle.
                if ((occ_q != '0) || push) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (pop) begin
                    counter_d = counter_q + CNT_W'(1);
                    if (head[8]) begin
                        state_d = S_FINAL;
                    end
                end
            end
            S_FINAL: begin
                if (bus.hash_ready) begin
                    counter_d = '0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            mem_q     <= '{default: '0};
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            occ_q     <= '0;
            counter_q <= '0;
        end else begin
            state_q   <= state_d;
            mem_q     <= mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            occ_q     <= occ_d;
            counter_q <= counter_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.m_valid   = m_valid;
    assign bus.message   = head[7:0];
    assign bus.fin_valid = (state_q == S_FINAL);
    assign bus.counter   = counter_q;
endmodule
